stereo_mixer: RTL and testbench



---
 rtl/stereo_mixer.sv | 156 +++++++++++++++
 tb/tb_stereo_mixer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_mixer.sv
// stereo_mixer: time-multiplexed stereo mixer.
// NUM_CH mono voices are snapshotted on in_ready and then accumulated into
// left/right sums at one channel per clock, using gain and a linear pan.
// The scaled sums are emitted as a single stereo pair with a one-cycle
// out_ready pulse.
// Build option: define MIXER_SATURATE_EN to clamp the output to the
// SAMPLE_W range. When it is undefined, the output wraps in two's complement.
module stereo_mixer #(
  parameter int NUM_CH   = 3,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4,
  parameter int PAN_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
  input  logic [NUM_CH*GAIN_W-1:0]     gain,
  input  logic [NUM_CH*PAN_W-1:0]      pan,
  input  logic                         in_ready,
  output logic [SAMPLE_W-1:0]          out_L,
  output logic [SAMPLE_W-1:0]          out_R,
  output logic                         out_ready,
  output logic                         busy,
  output logic                         overrun
);

  localparam int ACC_W = SAMPLE_W + GAIN_W + PAN_W + 1 + $clog2(NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SHIFT = GAIN_W - 1 + PAN_W;
  localparam logic [PAN_W:0] PAN_FULL = {1'b1, {PAN_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   last_ch;

  logic signed [SAMPLE_W-1:0] snap_s_p0 [NUM_CH];
  logic        [GAIN_W-1:0]   snap_g_p0 [NUM_CH];
  logic        [PAN_W-1:0]    snap_p_p0 [NUM_CH];

  logic        [IDX_W-1:0]    idx_p1;
  logic signed [ACC_W-1:0]    acc_l_p1, acc_r_p1;

  logic signed [ACC_W-1:0]    s_ext, g_ext, wl_ext, wr_ext, prod;
  logic signed [ACC_W-1:0]    acc_l_nxt, acc_r_nxt;
  logic signed [ACC_W-1:0]    sh_l, sh_r;
  logic        [PAN_W:0]      wl;

  // Narrow a scaled accumulator to the output width (clamp or wrap).
  function automatic logic [SAMPLE_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef MIXER_SATURATE_EN
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    min_v = -max_v - ACC_W'(1);
    if (v > max_v)      reduce = max_v[SAMPLE_W-1:0];
    else if (v < min_v) reduce = min_v[SAMPLE_W-1:0];
    else                reduce = v[SAMPLE_W-1:0];
`else
    reduce = v[SAMPLE_W-1:0];
`endif
  endfunction

  assign busy = (state_q != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A new mix is accepted from IDLE or straight out of DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last_ch = (idx_p1 == IDX_W'(NUM_CH - 1));
    case (state_q)
      IDLE: begin
        if (in_ready) begin
          state_d = ACCUM;
          accept  = 1'b1;
        end
      end
      ACCUM: begin
        if (last_ch) state_d = DONE;
      end
      DONE: begin
        if (in_ready) begin
          state_d = ACCUM;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: input snapshot, which isolates the mix from later input changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_s_p0[i] <= sample_in[i*SAMPLE_W +: SAMPLE_W];
        snap_g_p0[i] <= gain[i*GAIN_W +: GAIN_W];
        snap_p_p0[i] <= pan[i*PAN_W +: PAN_W];
      end
    end
  end

  // Per-channel weighted term for the channel currently selected by idx_p1.
  always_comb begin
    s_ext     = ACC_W'(snap_s_p0[idx_p1]);
    g_ext     = ACC_W'(snap_g_p0[idx_p1]);
    wl        = PAN_FULL - {1'b0, snap_p_p0[idx_p1]};
    wl_ext    = ACC_W'(wl);
    wr_ext    = ACC_W'(snap_p_p0[idx_p1]);
    prod      = s_ext * g_ext;
    acc_l_nxt = acc_l_p1 + prod * wl_ext;
    acc_r_nxt = acc_r_p1 + prod * wr_ext;
    sh_l      = acc_l_nxt >>> SHIFT;
    sh_r      = acc_r_nxt >>> SHIFT;
  end

  // Stage p1: accumulation. The output register is loaded on the last channel,
  // so the new pair and out_ready are both visible during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p1    <= '0;
      acc_l_p1  <= '0;
      acc_r_p1  <= '0;
      out_L     <= '0;
      out_R     <= '0;
      out_ready <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      if (accept) begin
        idx_p1   <= '0;
        acc_l_p1 <= '0;
        acc_r_p1 <= '0;
      end else if (state_q == ACCUM) begin
        idx_p1   <= idx_p1 + 1'b1;
        acc_l_p1 <= acc_l_nxt;
        acc_r_p1 <= acc_r_nxt;
        if (last_ch) begin
          out_L     <= reduce(sh_l);
          out_R     <= reduce(sh_r);
          out_ready <= 1'b1;
        end
      end
      if ((state_q == ACCUM) && in_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stereo_mixer.sv
// Directed testbench for stereo_mixer at its default parameters.
module tb_stereo_mixer;

  localparam int NUM_CH   = 3;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;
  localparam int PAN_W    = 3;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_CH*SAMPLE_W-1:0]  sample_in;
  logic [NUM_CH*GAIN_W-1:0]    gain;
  logic [NUM_CH*PAN_W-1:0]     pan;
  logic                        in_ready;
  logic [SAMPLE_W-1:0]         out_L, out_R;
  logic                        out_ready, busy, overrun;

  int checks = 0;
  int errors = 0;

  stereo_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .PAN_W(PAN_W)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .gain(gain), .pan(pan),
    .in_ready(in_ready), .out_L(out_L), .out_R(out_R), .out_ready(out_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic set_ch(input int ch, input int s, input int g, input int p);
    sample_in[ch*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(s);
    gain[ch*GAIN_W +: GAIN_W]          = GAIN_W'(g);
    pan[ch*PAN_W +: PAN_W]             = PAN_W'(p);
  endtask

  task automatic clear_all;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 0, 0, 0);
  endtask

  // Pulse in_ready for one cycle, then wait (bounded) for out_ready.
  // lat counts cycles from the in_ready cycle to the out_ready cycle.
  task automatic run_mix(output int lat);
    @(negedge clk);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    lat = 1;
    while (!out_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_ready = 1'b1;
    set_ch(0, 1000, 8, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_L !== 16'd0) begin errors++; $display("FAIL reset_out_L got %0d want 0", $signed(out_L)); end
    checks++; if (out_R !== 16'd0) begin errors++; $display("FAIL reset_out_R got %0d want 0", $signed(out_R)); end
    checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL reset_out_ready got %b want 0", out_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_hard_left;
    int lat;
    clear_all();
    set_ch(0, 1000, 8, 0);
    set_ch(1, 123, 0, 5);
    set_ch(2, -77, 0, 2);
    run_mix(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL hl_latency got %0d want 4", lat); end
    checks++; if (out_L !== 16'd1000) begin errors++; $display("FAIL hl_out_L got %0d want 1000", $signed(out_L)); end
    checks++; if (out_R !== 16'd0) begin errors++; $display("FAIL hl_out_R got %0d want 0", $signed(out_R)); end
    @(negedge clk);
    checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL hl_pulse_width got %b want 0", out_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hl_busy_after got %b want 0", busy); end
    checks++; if (out_L !== 16'd1000) begin errors++; $display("FAIL hl_out_L_held got %0d want 1000", $signed(out_L)); end
  endtask

  task automatic test_center_neg;
    int lat;
    clear_all();
    set_ch(0, -1000, 8, 4);
    run_mix(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL cn_latency got %0d want 4", lat); end
    checks++; if (out_L !== 16'(-500)) begin errors++; $display("FAIL cn_out_L got %0d want -500", $signed(out_L)); end
    checks++; if (out_R !== 16'(-500)) begin errors++; $display("FAIL cn_out_R got %0d want -500", $signed(out_R)); end
  endtask

  // Three channels with different gain/pan; the results need floor rounding.
  // L = (64000 - 8000 + 21600) / 64 = 1212.5 -> 1212
  // R = (0 - 56000 + 7200) / 64 = -762.5 -> -763
  task automatic test_multi_channel;
    int lat;
    clear_all();
    set_ch(0, 1000, 8, 0);
    set_ch(1, -2000, 4, 7);
    set_ch(2, 300, 12, 2);
    run_mix(lat);
    checks++; if (out_L !== 16'd1212) begin errors++; $display("FAIL mc_out_L got %0d want 1212", $signed(out_L)); end
    checks++; if (out_R !== 16'(-763)) begin errors++; $display("FAIL mc_out_R got %0d want -763", $signed(out_R)); end
  endtask

  // Maximum pan still leaks 1/8 to the left: 800*8*1/64 = 100, 800*8*7/64 = 700.
  task automatic test_max_pan;
    int lat;
    clear_all();
    set_ch(0, 800, 8, 7);
    run_mix(lat);
    checks++; if (out_L !== 16'd100) begin errors++; $display("FAIL mp_out_L got %0d want 100", $signed(out_L)); end
    checks++; if (out_R !== 16'd700) begin errors++; $display("FAIL mp_out_R got %0d want 700", $signed(out_R)); end
  endtask

  task automatic test_overflow;
    int lat;
    logic [SAMPLE_W-1:0] exp_l;
`ifdef MIXER_SATURATE_EN
    exp_l = 16'd32767;
`else
    exp_l = 16'(-27858);
`endif
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 30000, 15, 0);
    run_mix(lat);
    checks++; if (out_L !== exp_l) begin errors++; $display("FAIL ov_out_L got %0d want %0d", $signed(out_L), $signed(exp_l)); end
    checks++; if (out_R !== 16'd0) begin errors++; $display("FAIL ov_out_R got %0d want 0", $signed(out_R)); end
  endtask

  task automatic test_overrun;
    int lat;
    clear_all();
    set_ch(0, 1000, 8, 0);
    @(negedge clk);
    in_ready = 1'b1;                 // cycle T
    @(negedge clk);
    in_ready = 1'b0;                 // T+1
    @(negedge clk);
    set_ch(0, 2000, 8, 0);
    in_ready = 1'b1;                 // T+2, dropped
    @(negedge clk);
    in_ready = 1'b0;                 // T+3
    lat = 3;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL or_overrun got %b want 1", overrun); end
    while (!out_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL or_latency got %0d want 4", lat); end
    checks++; if (out_L !== 16'd1000) begin errors++; $display("FAIL or_out_L got %0d want 1000", $signed(out_L)); end
    // In the DONE cycle (T+4), a new in_ready must be accepted.
    set_ch(0, -1000, 8, 4);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;                 // T+5
    lat = 5;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL or_busy_accept got %b want 1", busy); end
    while (!out_ready && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL or_recover_latency got %0d want 8", lat); end
    checks++; if (out_L !== 16'(-500)) begin errors++; $display("FAIL or_recover_out_L got %0d want -500", $signed(out_L)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL or_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    clear_all();
    set_ch(0, 3000, 8, 0);
    @(negedge clk);
    in_ready = 1'b1;                 // T
    @(negedge clk);
    in_ready = 1'b0;                 // T+1
    @(negedge clk);
    reset = 1'b1;                    // T+2
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_L !== 16'd0) begin errors++; $display("FAIL rm_out_L got %0d want 0", $signed(out_L)); end
    checks++; if (out_R !== 16'd0) begin errors++; $display("FAIL rm_out_R got %0d want 0", $signed(out_R)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rm_overrun got %b want 0", overrun); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_ready) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_out_ready got %0d pulses want 0", seen); end
    set_ch(0, 1000, 8, 0);
    run_mix(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rm_fresh_latency got %0d want 4", lat); end
    checks++; if (out_L !== 16'd1000) begin errors++; $display("FAIL rm_fresh_out_L got %0d want 1000", $signed(out_L)); end
  endtask

  task automatic test_isolation;
    int lat;
    clear_all();
    set_ch(0, 1000, 8, 0);
    @(negedge clk);
    in_ready = 1'b1;                 // T
    @(negedge clk);
    in_ready = 1'b0;                 // T+1: change the inputs mid-mix
    set_ch(0, 5000, 15, 4);
    set_ch(1, -3000, 8, 0);
    lat = 1;
    while (!out_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL iso_latency got %0d want 4", lat); end
    checks++; if (out_L !== 16'd1000) begin errors++; $display("FAIL iso_out_L got %0d want 1000", $signed(out_L)); end
    checks++; if (out_R !== 16'd0) begin errors++; $display("FAIL iso_out_R got %0d want 0", $signed(out_R)); end
  endtask

  initial begin
    reset = 1'b1;
    in_ready = 1'b0;
    sample_in = '0;
    gain = '0;
    pan = '0;
    test_reset();
    test_hard_left();
    test_center_neg();
    test_multi_channel();
    test_max_pan();
    test_overflow();
    test_overrun();
    test_reset_mid();
    test_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
